// File: rtl/rob_param_pkg.sv
// Shared ROB definitions: entry kind encodings and default sizing,
// also used by the issue unit and the load/store buffer.
package rob_param_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_XLEN  = 32;

  typedef enum logic [1:0] {
    ROB_ALU    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2
  } rob_kind_e;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// ROB pointer control: head/tail with power-of-two wrap, occupancy count.
// Ports: clk, rst (sync, active-high), inc/dec/clr strobes; head, tail, count, full, empty.
module rob_ptr_ctrl #(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [IDX_W-1:0] head,
  output logic [IDX_W-1:0] tail,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (inc) tail_d = tail_q + IDX_W'(1);
      if (dec) head_d = head_q + IDX_W'(1);
      if (inc && !dec) count_d = count_q + (IDX_W+1)'(1);
      else if (dec && !inc) count_d = count_q - (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
  assign full  = (count_q == (IDX_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/rob_param.sv
// In-order-retire reorder buffer: tail issue, out-of-order writeback on
// ALU (wb0) and LSB (wb1) ports, operand lookup with bypass, registered
// commit to RF / LSB, single-cycle misprediction flush.
// Ports: clk, rst (sync, active-high), rdy stall; issue_*, q1_*/q2_*,
// wb0_*/wb1_*, rf_*, st_*, flush/new_pc, count/empty.
// Optional: ROB_PERF_EN adds perf_commits / perf_flushes counters.
module rob_param
  import rob_param_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int XLEN  = ROB_XLEN,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [1:0]       issue_kind,
  input  logic [XLEN-1:0]  issue_pred_pc,
  output logic             issue_ready,
  output logic [IDX_W-1:0] issue_idx,
  input  logic [IDX_W-1:0] q1_idx,
  input  logic [IDX_W-1:0] q2_idx,
  output logic             q1_hit,
  output logic             q2_hit,
  output logic [XLEN-1:0]  q1_val,
  output logic [XLEN-1:0]  q2_val,
  input  logic             wb0_valid,
  input  logic [IDX_W-1:0] wb0_idx,
  input  logic [XLEN-1:0]  wb0_val,
  input  logic [XLEN-1:0]  wb0_npc,
  input  logic             wb1_valid,
  input  logic [IDX_W-1:0] wb1_idx,
  input  logic [XLEN-1:0]  wb1_val,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [IDX_W-1:0] rf_idx,
  output logic [XLEN-1:0]  rf_val,
  output logic             st_commit,
  output logic [IDX_W-1:0] st_idx,
  output logic             flush,
  output logic [XLEN-1:0]  new_pc,
  output logic [IDX_W:0]   count,
  output logic             empty
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]      perf_commits,
  output logic [31:0]      perf_flushes
`endif
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;
  rob_kind_e        kind_q [DEPTH];
  rob_kind_e        kind_d [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [XLEN-1:0]  val_q  [DEPTH];
  logic [XLEN-1:0]  val_d  [DEPTH];
  logic [XLEN-1:0]  npc_q  [DEPTH];
  logic [XLEN-1:0]  npc_d  [DEPTH];
  logic [XLEN-1:0]  pred_q [DEPTH];
  logic [XLEN-1:0]  pred_d [DEPTH];

  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [IDX_W-1:0] rf_idx_q, rf_idx_d;
  logic [XLEN-1:0]  rf_val_q, rf_val_d;
  logic             st_commit_q, st_commit_d;
  logic [IDX_W-1:0] st_idx_q, st_idx_d;
  logic             flush_q, flush_d;
  logic [XLEN-1:0]  new_pc_q, new_pc_d;

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic             full;
  logic             do_issue;
  logic             do_commit;
  logic             do_flush;
  logic             wb0_ok;
  logic             wb1_ok;
  logic             mispred;

  // While a flush is pending, younger entries behind the branch must not
  // retire, so commit is suppressed in the flush cycle.
  assign issue_ready = !full && !flush_q;
  assign do_issue    = rdy && issue_valid && issue_ready;
  assign do_commit   = rdy && !flush_q && busy_q[head] && done_q[head];
  assign do_flush    = rdy && flush_q;
  assign wb1_ok      = rdy && !flush_q && wb1_valid && busy_q[wb1_idx];
  assign wb0_ok      = rdy && !flush_q && wb0_valid && busy_q[wb0_idx]
                    && !(wb1_ok && wb1_idx == wb0_idx);
  assign mispred     = (kind_q[head] == ROB_BRANCH)
                    && (npc_q[head] != pred_q[head]);

  rob_ptr_ctrl #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (do_issue),
    .dec  (do_commit),
    .clr  (do_flush),
    .head (head),
    .tail (tail),
    .count(count),
    .full (full),
    .empty(empty)
  );

  assign issue_idx = tail;

  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    kind_d = kind_q;
    rd_d   = rd_q;
    val_d  = val_q;
    npc_d  = npc_q;
    pred_d = pred_q;
    if (do_flush) begin
      busy_d = '0;
      done_d = '0;
    end else begin
      if (do_commit) busy_d[head] = 1'b0;
      if (do_issue) begin
        busy_d[tail] = 1'b1;
        done_d[tail] = 1'b0;
        kind_d[tail] = rob_kind_e'(issue_kind);
        rd_d[tail]   = issue_rd;
        pred_d[tail] = issue_pred_pc;
        // Default npc to the prediction so a branch resolved on the
        // LSB port (no npc) is treated as correctly predicted.
        npc_d[tail]  = issue_pred_pc;
      end
      if (wb0_ok) begin
        done_d[wb0_idx] = 1'b1;
        val_d[wb0_idx]  = wb0_val;
        npc_d[wb0_idx]  = wb0_npc;
      end
      if (wb1_ok) begin
        done_d[wb1_idx] = 1'b1;
        val_d[wb1_idx]  = wb1_val;
      end
    end
  end

  always_comb begin
    q1_hit = busy_q[q1_idx] && done_q[q1_idx];
    q1_val = val_q[q1_idx];
    if (wb0_valid && wb0_idx == q1_idx) begin
      q1_hit = 1'b1;
      q1_val = wb0_val;
    end
    if (wb1_valid && wb1_idx == q1_idx) begin
      q1_hit = 1'b1;
      q1_val = wb1_val;
    end
    q2_hit = busy_q[q2_idx] && done_q[q2_idx];
    q2_val = val_q[q2_idx];
    if (wb0_valid && wb0_idx == q2_idx) begin
      q2_hit = 1'b1;
      q2_val = wb0_val;
    end
    if (wb1_valid && wb1_idx == q2_idx) begin
      q2_hit = 1'b1;
      q2_val = wb1_val;
    end
  end

  always_comb begin
    rf_we_d     = 1'b0;
    st_commit_d = 1'b0;
    flush_d     = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_idx_d    = rf_idx_q;
    rf_val_d    = rf_val_q;
    st_idx_d    = st_idx_q;
    new_pc_d    = new_pc_q;
    if (do_commit) begin
      rf_rd_d  = rd_q[head];
      rf_idx_d = head;
      rf_val_d = val_q[head];
      case (kind_q[head])
        ROB_STORE: begin
          st_commit_d = 1'b1;
          st_idx_d    = head;
        end
        ROB_BRANCH: begin
          rf_we_d = (rd_q[head] != 5'd0);
          if (mispred) begin
            flush_d  = 1'b1;
            new_pc_d = npc_q[head];
          end
        end
        default: rf_we_d = (rd_q[head] != 5'd0);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      done_q      <= '0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_idx_q    <= '0;
      rf_val_q    <= '0;
      st_commit_q <= 1'b0;
      st_idx_q    <= '0;
      flush_q     <= 1'b0;
      new_pc_q    <= '0;
    end else if (rdy) begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_idx_q    <= rf_idx_d;
      rf_val_q    <= rf_val_d;
      st_commit_q <= st_commit_d;
      st_idx_q    <= st_idx_d;
      flush_q     <= flush_d;
      new_pc_q    <= new_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      kind_q <= kind_d;
      rd_q   <= rd_d;
      val_q  <= val_d;
      npc_q  <= npc_d;
      pred_q <= pred_d;
    end
  end

  // Pulses are held through a stall and masked, so each is seen
  // for exactly one un-stalled cycle.
  assign rf_we     = rf_we_q && rdy;
  assign st_commit = st_commit_q && rdy;
  assign flush     = flush_q && rdy;
  assign rf_rd     = rf_rd_q;
  assign rf_idx    = rf_idx_q;
  assign rf_val    = rf_val_q;
  assign st_idx    = st_idx_q;
  assign new_pc    = new_pc_q;

`ifdef ROB_PERF_EN
  logic [31:0] perf_commits_q, perf_commits_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  always_comb begin
    perf_commits_d = perf_commits_q;
    perf_flushes_d = perf_flushes_q;
    if (do_commit && perf_commits_q != 32'hFFFF_FFFF)
      perf_commits_d = perf_commits_q + 32'd1;
    if (do_flush && perf_flushes_q != 32'hFFFF_FFFF)
      perf_flushes_d = perf_flushes_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commits_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_commits_q <= perf_commits_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_commits = perf_commits_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule
